// File: rtl/axi_ddr3_pkg.sv
// Shared definitions for the AXI-to-DDR3 bridge: arbiter state encodings,
// AXI burst/response constants and the default hazard line size.
package axi_ddr3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WCMD = 2'd1,
    ST_WDAT = 2'd2,
    ST_RCMD = 2'd3
  } arb_state_t;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int unsigned LINE_BITS_DEFAULT = 4;

endpackage

// File: rtl/ddr3_req_arbiter.sv
// Arbitrates the DDR3 controller command port between the AXI write and read
// paths: alternating priority, read-after-write line hazard override, and the
// port stays owned by a write until its last data beat has gone in.
module ddr3_req_arbiter
  import axi_ddr3_pkg::*;
#(
  parameter int unsigned ADDRS        = 32,
  parameter int unsigned AXI_ID_WIDTH = 4,
  parameter int unsigned LINE_BITS    = LINE_BITS_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_store_i,
  output logic                    wr_accept_o,
  input  logic [ADDRS-1:0]        wr_addr_i,
  input  logic [AXI_ID_WIDTH-1:0] wr_id_i,
  input  logic                    wr_last_i,
  input  logic                    rd_fetch_i,
  output logic                    rd_accept_o,
  input  logic [ADDRS-1:0]        rd_addr_i,
  input  logic [AXI_ID_WIDTH-1:0] rd_id_i,
  output logic                    ctl_valid_o,
  input  logic                    ctl_ready_i,
  output logic                    ctl_write_o,
  output logic [ADDRS-1:0]        ctl_addr_o,
  output logic [AXI_ID_WIDTH-1:0] ctl_id_o
);

  arb_state_t              state;
  arb_state_t              state_nxt;
  logic                    prio;
  logic                    prio_nxt;
  logic                    ctl_valid_nxt;
  logic                    ctl_write_nxt;
  logic [ADDRS-1:0]        ctl_addr_nxt;
  logic [AXI_ID_WIDTH-1:0] ctl_id_nxt;
  logic                    line_hit;
  logic                    grant_wr;
  logic                    grant_rd;

  // Same-line requests: the write must land before the read is issued.
  assign line_hit = (wr_addr_i[ADDRS-1:LINE_BITS] == rd_addr_i[ADDRS-1:LINE_BITS]);

  always_comb begin
    grant_wr = (state == ST_IDLE) & wr_store_i & (~rd_fetch_i | ~prio | line_hit);
    grant_rd = (state == ST_IDLE) & rd_fetch_i & ~grant_wr;
  end

  // State and command register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      prio        <= 1'b0;
      ctl_valid_o <= 1'b0;
      ctl_write_o <= 1'b0;
      ctl_addr_o  <= '0;
      ctl_id_o    <= '0;
    end else begin
      state       <= state_nxt;
      prio        <= prio_nxt;
      ctl_valid_o <= ctl_valid_nxt;
      ctl_write_o <= ctl_write_nxt;
      ctl_addr_o  <= ctl_addr_nxt;
      ctl_id_o    <= ctl_id_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_wr)      state_nxt = ST_WCMD;
        else if (grant_rd) state_nxt = ST_RCMD;
      end
      ST_WCMD: if (ctl_ready_i) state_nxt = ST_WDAT;
      ST_WDAT: if (wr_last_i)   state_nxt = ST_IDLE;
      ST_RCMD: if (ctl_ready_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: command register loads on grant, clears on handshake
  always_comb begin
    prio_nxt      = prio;
    ctl_valid_nxt = ctl_valid_o;
    ctl_write_nxt = ctl_write_o;
    ctl_addr_nxt  = ctl_addr_o;
    ctl_id_nxt    = ctl_id_o;
    wr_accept_o   = 1'b0;
    rd_accept_o   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_wr) begin
          prio_nxt      = 1'b1;
          ctl_valid_nxt = 1'b1;
          ctl_write_nxt = 1'b1;
          ctl_addr_nxt  = wr_addr_i;
          ctl_id_nxt    = wr_id_i;
        end else if (grant_rd) begin
          prio_nxt      = 1'b0;
          ctl_valid_nxt = 1'b1;
          ctl_write_nxt = 1'b0;
          ctl_addr_nxt  = rd_addr_i;
          ctl_id_nxt    = rd_id_i;
        end
      end
      ST_WCMD: begin
        wr_accept_o = ctl_ready_i;
        if (ctl_ready_i) ctl_valid_nxt = 1'b0;
      end
      ST_RCMD: begin
        rd_accept_o = ctl_ready_i;
        if (ctl_ready_i) ctl_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Requesters must hold their request until the accept cycle.
  a_wr_held: assert property (@(posedge clock) disable iff (reset)
    (state == ST_WCMD) |-> wr_store_i)
    else $error("write request dropped before acceptance");

  a_rd_held: assert property (@(posedge clock) disable iff (reset)
    (state == ST_RCMD) |-> rd_fetch_i)
    else $error("read request dropped before acceptance");

  a_one_accept: assert property (@(posedge clock) disable iff (reset)
    !(wr_accept_o && rd_accept_o))
    else $error("write and read accepted together");

endmodule

// File: doc/ddr3_req_arbiter.md
# ddr3_req_arbiter

Shares the single SDRAM memory-controller command port between the AXI write path and the AXI read path. It grants one request at a time, with alternating priority and a read-after-write line hazard override. It holds the command port for the whole write-data burst, so that commands and write-data are never interleaved. It sits between the write/read datapaths and the DDR3 controller front-end.

## Interface
- ADDRS, 32, address width.
- AXI_ID_WIDTH, 4, transaction-ID width.
- LINE_BITS, 4, low address bits ignored for hazard compare (16-byte line).
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- wr_store_i  in  1  write request pending; held until accepted.
- wr_accept_o  out  1  one-cycle write-request acceptance.
- wr_addr_i  in  ADDRS  write address.
- wr_id_i  in  AXI_ID_WIDTH  write ID.
- wr_last_i  in  1  final write-data beat handshaken into the controller (mem_valid & mem_ready & mem_last).
- rd_fetch_i  in  1  read request pending; held until accepted.
- rd_accept_o  out  1  one-cycle read-request acceptance.
- rd_addr_i  in  ADDRS  read address.
- rd_id_i  in  AXI_ID_WIDTH  read ID.
- ctl_valid_o  out  1  command valid to controller.
- ctl_ready_i  in  1  controller accepts command.
- ctl_write_o  out  1  1 = write, 0 = read.
- ctl_addr_o  out  ADDRS  command address.
- ctl_id_o  out  AXI_ID_WIDTH  command ID.

## Operation
- States: ST_IDLE, ST_WCMD, ST_WDAT, ST_RCMD.
- Priority bit `prio`: 0 = write preferred, 1 = read preferred.
  - After a write grant, `prio` <= 1.
  - After a read grant, `prio` <= 0.
- ST_IDLE: evaluate requests.
  - Only one request pending: grant it.
  - Both pending: grant per `prio`.
  - Hazard override: if both pending and wr_addr_i[ASB:LINE_BITS] == rd_addr_i[ASB:LINE_BITS], the write wins regardless of `prio`, and `prio` is still set to 1.
  - On a write grant: go to ST_WCMD. On a read grant: go to ST_RCMD.
  - On either grant, register address and ID into ctl_addr_o/ctl_id_o, set ctl_write_o, and set ctl_valid_o=1.
- ST_WCMD: hold ctl_valid_o until ctl_ready_i.
  - On handshake: ctl_valid_o<=0, go to ST_WDAT.
- ST_WDAT: command port is owned by the write; no grants are made.
  - On wr_last_i: go to ST_IDLE.
- ST_RCMD: hold ctl_valid_o until ctl_ready_i.
  - On handshake: ctl_valid_o<=0, go to ST_IDLE.
- wr_accept_o = (state==ST_WCMD) & ctl_ready_i.
- rd_accept_o = (state==ST_RCMD) & ctl_ready_i.
- Both accepts are combinational, coincide with the controller handshake, and can never both be 1.
- wr_last_i outside ST_WDAT is ignored.
- Command outputs (ctl_addr_o, ctl_id_o, ctl_write_o) are stable while ctl_valid_o=1.
- Requester inputs may change after their accept cycle.
- Requests dropped before acceptance are protocol violations. Simulation flags them with $error; behaviour is then undefined.

## Timing
- Reset (asynchronous):
  - state=ST_IDLE, prio=0.
  - ctl_valid_o=0, ctl_write_o=0, ctl_addr_o=0, ctl_id_o=0.
  - wr_accept_o=0, rd_accept_o=0.
- Reset asserted mid-burst aborts immediately to ST_IDLE. Upstream paths are reset by the same signal.
- Request latency: a request sampled in ST_IDLE at cycle N gives ctl_valid_o=1 at cycle N+1.
  - Accept occurs at the earliest in cycle N+1, if ctl_ready_i=1.
- Read throughput: one command per 2 cycles minimum (IDLE→RCMD→IDLE).
- Write occupancy: 2 cycles plus the data burst. The next grant is evaluated in the cycle after wr_last_i.
- ctl_ready_i held low stalls indefinitely; there is no timeout.
- wr_last_i in the same cycle as the write command handshake is not possible (data follows acceptance), so the FSM need not handle it.

## Structure
- Shared package (axi_ddr3_pkg) holds:
  - the state encodings ST_IDLE/ST_WCMD/ST_WDAT/ST_RCMD;
  - BURST_INCR and AXI_RESP_OKAY;
  - default LINE_BITS.
- Single flat module; no sub-module is natural.
- The line compare is a small combinational term inside the module.

## Test plan
- Write only: wr_store_i=1, addr 0x100, id 3, ctl_ready_i=1.
  - ctl_valid_o=1, ctl_write_o=1, ctl_addr_o=0x100, ctl_id_o=3 one cycle later.
  - wr_accept_o pulses once.
  - No grant until wr_last_i.
- Read only: back-to-back reads (addrs 0x200, 0x210) with ctl_ready_i=1.
  - Commands issued two cycles apart.
  - rd_accept_o pulses once per read.
- Both pending, distinct lines (write 0x000, read 0x040), repeated:
  - grants alternate W, R, W, R starting with write after reset.
- Hazard: prio=1, write 0x1230 and read 0x1238 pending.
  - Write granted first; read granted after wr_last_i.
- Backpressure: ctl_ready_i=0 for 5 cycles in ST_WCMD.
  - ctl_valid_o, ctl_addr_o and ctl_id_o stable throughout.
  - wr_accept_o only on the ready cycle.
- Reset during ST_WDAT: all outputs 0 immediately (asynchronous).
  - A pending read is granted first after release (prio=0, write absent).
